// File: rtl/tinyml_cam_scale_up_2x_nn.sv
// Purpose: 2x nearest-neighbour upscaler on a 2-pixel-per-clock RGB stream; each input line is emitted twice, the second copy replayed from a line buffer.
// Latency: 1 cycle from an accepted input word to its first output word; the replay row starts 1 cycle after the fill row ends.
// Backpressure: the output register loads only when empty or accepted; in_ready is low while stalled, on the second half of a word, and during prime/replay.
module tinyml_cam_scale_up_2x_nn #(
   parameter int P_DEPTH         = 8,
   parameter int OUT_FRAME_WIDTH = 1080
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sof,
   input  logic [2*P_DEPTH-1:0] in_red,
   input  logic [2*P_DEPTH-1:0] in_green,
   input  logic [2*P_DEPTH-1:0] in_blue,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*P_DEPTH-1:0] out_red,
   output logic [2*P_DEPTH-1:0] out_green,
   output logic [2*P_DEPTH-1:0] out_blue,
   output logic [10:0]          out_x,
   output logic [10:0]          out_y
);

   localparam int W_WORDS = OUT_FRAME_WIDTH / 4;
   localparam int WC_W    = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;
   localparam int PX_W    = 2 * P_DEPTH;
   localparam int LB_W    = 6 * P_DEPTH;
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(W_WORDS - 1);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_PRIME  = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   // Control state
   state_t              r_state;
   state_t              w_state_nxt;
   logic [WC_W-1:0]     r_wcnt;
   logic [WC_W-1:0]     w_wcnt_nxt;
   logic                r_phase;
   logic                w_phase_nxt;
   logic [10:0]         r_in_line;
   logic [10:0]         w_line_nxt;

   // Datapath state
   logic [3*P_DEPTH-1:0] r_hold;      // {blue.p1, green.p1, red.p1} of the word being filled
   logic [LB_W-1:0]      r_linebuf [W_WORDS];
   logic [LB_W-1:0]      r_rd;        // registered line-buffer read word {blue, green, red}

   logic                 r_out_valid;
   logic [PX_W-1:0]      r_out_red;
   logic [PX_W-1:0]      r_out_green;
   logic [PX_W-1:0]      r_out_blue;
   logic [10:0]          r_out_x;
   logic [10:0]          r_out_y;

   // Combinational controls
   logic                 w_adv;
   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_load;
   logic [PX_W-1:0]      w_red_nxt;
   logic [PX_W-1:0]      w_green_nxt;
   logic [PX_W-1:0]      w_blue_nxt;
   logic [10:0]          w_x_nxt;
   logic [10:0]          w_y_nxt;
   logic                 w_hold_ld;
   logic                 w_wr_en;
   logic [WC_W-1:0]      w_wr_addr;
   logic                 w_rd_en;
   logic [WC_W-1:0]      w_rd_addr;
   logic [WC_W-1:0]      w_wcnt_eff;
   logic [10:0]          w_line_eff;

   function automatic logic [PX_W-1:0] dup(input logic [P_DEPTH-1:0] p);
      return {p, p};
   endfunction

   assign w_adv      = ~r_out_valid | out_ready;
   assign w_in_ready = rst_n & (r_state == S_FILL) & ~r_phase & w_adv;
   assign w_accept   = in_valid & w_in_ready;

   // Next-state, counters and output-word selection for fill, prime and replay
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_phase_nxt = r_phase;
      w_line_nxt  = r_in_line;
      w_load      = 1'b0;
      w_red_nxt   = '0;
      w_green_nxt = '0;
      w_blue_nxt  = '0;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_hold_ld   = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_addr   = r_wcnt;
      w_rd_en     = 1'b0;
      w_rd_addr   = '0;
      // A start-of-frame word restarts the line at word 0 of row 0, dropping any partial line.
      w_wcnt_eff  = in_sof ? '0 : r_wcnt;
      w_line_eff  = in_sof ? '0 : r_in_line;
      case (r_state)
         S_FILL: begin
            if (!r_phase) begin
               if (w_accept) begin
                  w_load      = 1'b1;
                  w_red_nxt   = dup(in_red[P_DEPTH-1:0]);
                  w_green_nxt = dup(in_green[P_DEPTH-1:0]);
                  w_blue_nxt  = dup(in_blue[P_DEPTH-1:0]);
                  w_x_nxt     = 11'({w_wcnt_eff, 1'b0});
                  w_y_nxt     = {w_line_eff[9:0], 1'b0};
                  w_hold_ld   = 1'b1;
                  w_wr_en     = 1'b1;
                  w_wr_addr   = w_wcnt_eff;
                  w_wcnt_nxt  = w_wcnt_eff;
                  w_line_nxt  = w_line_eff;
                  w_phase_nxt = 1'b1;
               end
            end else if (w_adv) begin
               w_load      = 1'b1;
               w_red_nxt   = dup(r_hold[P_DEPTH-1:0]);
               w_green_nxt = dup(r_hold[2*P_DEPTH-1:P_DEPTH]);
               w_blue_nxt  = dup(r_hold[3*P_DEPTH-1:2*P_DEPTH]);
               w_x_nxt     = 11'({r_wcnt, 1'b1});
               w_y_nxt     = {r_in_line[9:0], 1'b0};
               w_phase_nxt = 1'b0;
               if (r_wcnt == LAST_WORD) begin
                  w_wcnt_nxt  = '0;
                  w_state_nxt = S_PRIME;
               end else begin
                  w_wcnt_nxt  = r_wcnt + 1'b1;
               end
            end
         end
         S_PRIME: begin
            // Fetch word 0 so the replay row can start without a bubble per word.
            w_rd_en     = 1'b1;
            w_rd_addr   = '0;
            w_state_nxt = S_REPEAT;
         end
         S_REPEAT: begin
            if (w_adv) begin
               w_load  = 1'b1;
               w_y_nxt = {r_in_line[9:0], 1'b1};
               if (!r_phase) begin
                  w_red_nxt   = dup(r_rd[P_DEPTH-1:0]);
                  w_green_nxt = dup(r_rd[PX_W+P_DEPTH-1:PX_W]);
                  w_blue_nxt  = dup(r_rd[2*PX_W+P_DEPTH-1:2*PX_W]);
                  w_x_nxt     = 11'({r_wcnt, 1'b0});
                  w_phase_nxt = 1'b1;
               end else begin
                  w_red_nxt   = dup(r_rd[PX_W-1:P_DEPTH]);
                  w_green_nxt = dup(r_rd[2*PX_W-1:PX_W+P_DEPTH]);
                  w_blue_nxt  = dup(r_rd[3*PX_W-1:2*PX_W+P_DEPTH]);
                  w_x_nxt     = 11'({r_wcnt, 1'b1});
                  w_phase_nxt = 1'b0;
                  if (r_wcnt == LAST_WORD) begin
                     w_wcnt_nxt  = '0;
                     w_line_nxt  = r_in_line + 1'b1;
                     w_state_nxt = S_FILL;
                  end else begin
                     // Next word is read on the same edge the current p1 is loaded out.
                     w_wcnt_nxt  = r_wcnt + 1'b1;
                     w_rd_en     = 1'b1;
                     w_rd_addr   = r_wcnt + 1'b1;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = S_FILL;
         end
      endcase
   end

   // State register and line/word counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_FILL;
         r_wcnt    <= '0;
         r_phase   <= 1'b0;
         r_in_line <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_wcnt    <= w_wcnt_nxt;
         r_phase   <= w_phase_nxt;
         r_in_line <= w_line_nxt;
      end
   end

   // Second-pixel holding register for the fill row
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hold <= '0;
      end else if (w_hold_ld) begin
         r_hold <= {in_blue[PX_W-1:P_DEPTH], in_green[PX_W-1:P_DEPTH], in_red[PX_W-1:P_DEPTH]};
      end
   end

   // Line buffer write: every accepted word is stored for the replay row
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_linebuf[w_wr_addr] <= {in_blue, in_green, in_red};
      end
   end

   // Line buffer registered read; holds its value across output stalls
   always_ff @(posedge clk) begin
      if (w_rd_en) begin
         r_rd <= r_linebuf[w_rd_addr];
      end
   end

   // Output register: loads only when empty or being accepted downstream
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_red   <= '0;
         r_out_green <= '0;
         r_out_blue  <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
      end else if (w_adv) begin
         r_out_valid <= w_load;
         if (w_load) begin
            r_out_red   <= w_red_nxt;
            r_out_green <= w_green_nxt;
            r_out_blue  <= w_blue_nxt;
            r_out_x     <= w_x_nxt;
            r_out_y     <= w_y_nxt;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_red   = r_out_red;
   assign out_green = r_out_green;
   assign out_blue  = r_out_blue;
   assign out_x     = r_out_x;
   assign out_y     = r_out_y;

endmodule

// File: tb/tb_tinyml_cam_scale_up_2x_nn.sv
// Purpose: self-checking bench for the 2x nearest-neighbour upscaler against a line-level reference model.
// Latency: expectations are ordered by output word, independent of cycle timing.
// Backpressure: out_ready is driven either constantly high or randomly toggled.
module tb_tinyml_cam_scale_up_2x_nn;

   localparam int P   = 8;
   localparam int OFW = 16;
   localparam int W   = OFW / 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sof;
   logic [15:0] in_red;
   logic [15:0] in_green;
   logic [15:0] in_blue;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_red;
   logic [15:0] out_green;
   logic [15:0] out_blue;
   logic [10:0] out_x;
   logic [10:0] out_y;

   // expected output word: {red, green, blue, x, y}
   typedef logic [69:0] exp_t;

   exp_t        exp_q[$];
   logic [47:0] m_words[$];   // current input line, {blue, green, red}
   int          m_line = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   bit          rnd_rdy = 1'b0;
   bit          rnd_gap = 1'b0;
   bit          acc = 1'b0;

   always #5 clk = ~clk;

   tinyml_cam_scale_up_2x_nn #(
      .P_DEPTH(P),
      .OUT_FRAME_WIDTH(OFW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sof(in_sof),
      .in_red(in_red),
      .in_green(in_green),
      .in_blue(in_blue),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_red(out_red),
      .out_green(out_green),
      .out_blue(out_blue),
      .out_x(out_x),
      .out_y(out_y)
   );

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input int x, input int y);
      return {r, r, g, g, b, b, 11'(x), 11'(y)};
   endfunction

   // Reference model: each word gives two fill words on row 2L; a full line replays on row 2L+1.
   task automatic model_accept(input bit sof, input logic [47:0] w);
      int k;
      if (sof) begin
         m_line = 0;
         m_words.delete();
      end
      k = m_words.size();
      exp_q.push_back(mk(w[7:0],  w[23:16], w[39:32], 2*k,     2*m_line));
      exp_q.push_back(mk(w[15:8], w[31:24], w[47:40], 2*k + 1, 2*m_line));
      m_words.push_back(w);
      if (m_words.size() == W) begin
         foreach (m_words[j]) begin
            exp_q.push_back(mk(m_words[j][7:0],  m_words[j][23:16], m_words[j][39:32], 2*j,     2*m_line + 1));
            exp_q.push_back(mk(m_words[j][15:8], m_words[j][31:24], m_words[j][47:40], 2*j + 1, 2*m_line + 1));
         end
         m_line++;
         m_words.delete();
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_words.delete();
      m_line = 0;
   endtask

   // One clock: entered and left at a falling edge; samples just after it.
   task automatic run_cycle();
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("extra_out", 70'(out_valid), 70'd0);
         end else begin
            chk("out_word", {out_red, out_green, out_blue, out_x, out_y}, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      if (acc) model_accept(in_sof, {in_blue, in_green, in_red});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_word(input bit sof, input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
      bit done;
      done = 1'b0;
      in_valid = 1'b0;
      if (rnd_gap) repeat ($urandom_range(0, 2)) run_cycle();
      in_valid = 1'b1;
      in_sof   = sof;
      in_red   = r;
      in_green = g;
      in_blue  = b;
      for (int i = 0; i < 200 && !done; i++) begin
         run_cycle();
         done = acc;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("send_accepted", 70'(done), 70'd1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) run_cycle();
      repeat (6) run_cycle();
      chk("drain_empty", 70'(exp_q.size()), 70'd0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 70'(out_valid), 70'd0);
      chk("rst_in_ready", 70'(in_ready), 70'd0);
      chk("rst_out_data", {out_red, out_green, out_blue, out_x, out_y}, 70'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      model_clear();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  c17;
      int  c68;
      bit  prev;
      bit  found;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_red    = '0;
      in_green  = '0;
      in_blue   = '0;
      out_ready = 1'b1;
      @(negedge clk);
      do_reset();

      // Incrementing red pairs, no stalls
      rnd_rdy = 1'b0;
      rnd_gap = 1'b0;
      for (int k = 0; k < 8; k++)
         send_word(k == 0, {8'(2*k + 2), 8'(2*k + 1)}, 16'($urandom), 16'($urandom));
      drain();

      // Same sequence under random output stalls and input gaps
      rnd_rdy = 1'b1;
      rnd_gap = 1'b1;
      for (int k = 0; k < 8; k++)
         send_word(k == 0, {8'(2*k + 2), 8'(2*k + 1)}, 16'($urandom), 16'($urandom));
      drain();

      // Start of frame on the third word of line 1: partial line is not replayed
      for (int k = 0; k < 4; k++)
         send_word(k == 0, 16'($urandom), 16'($urandom), 16'($urandom));
      for (int k = 0; k < 6; k++)
         send_word(k == 2, 16'($urandom), 16'($urandom), 16'($urandom));
      drain();

      // Constant green over two lines: four rows, green alternating per pixel
      for (int k = 0; k < 8; k++)
         send_word(k == 0, 16'($urandom), 16'hAA55, 16'($urandom));
      drain();

      // Input valid held high, no stalls: acceptance rate and in_ready duty
      do_reset();
      rnd_rdy  = 1'b0;
      rnd_gap  = 1'b0;
      c17      = 0;
      c68      = 0;
      prev     = 1'b0;
      in_valid = 1'b1;
      in_sof   = 1'b1;
      in_red   = 16'($urandom);
      in_green = 16'($urandom);
      in_blue  = 16'($urandom);
      for (int c = 0; c < 68; c++) begin
         run_cycle();
         chk("in_ready_duty", 70'(prev && acc), 70'd0);
         prev = acc;
         if (acc) begin
            c68++;
            if (c < 17) c17++;
            in_sof   = 1'b0;
            in_red   = 16'($urandom);
            in_green = 16'($urandom);
            in_blue  = 16'($urandom);
         end
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("accepts_first_17", 70'(c17), 70'd4);
      chk("accepts_68", 70'(c68), 70'd16);
      drain();

      // Reset during the replay row, word 2
      for (int k = 0; k < 4; k++)
         send_word(k == 0, 16'($urandom), 16'($urandom), 16'($urandom));
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         found = out_valid && out_y[0] && (out_x == 11'd4);
         if (!found) run_cycle();
      end
      chk("reached_replay_word2", 70'(found), 70'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", 70'(out_valid), 70'd0);
      chk("midrst_in_ready", 70'(in_ready), 70'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      for (int k = 0; k < 4; k++)
         send_word(1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
      drain();

      // Random traffic with stalls, gaps and occasional frame restarts
      rnd_rdy = 1'b1;
      rnd_gap = 1'b1;
      for (int k = 0; k < 14; k++)
         send_word((k == 0) || ($urandom_range(0, 9) == 0), 16'($urandom), 16'($urandom), 16'($urandom));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
